im_arbiter: RTL
===============

Name: im_arbiter

Overview:
- Shares the single-port, 4096 x 16 synchronous instruction/dictionary RAM between two requesters: the CPU fetch port (read-only) and the host loader port (read/write).
- The loader port fills code (words 0-2047) and dictionary (words 2048-4095) regions.
- The CPU has fixed priority, with a starvation guard for the loader.
- The block also enforces write protection of the code region and returns read data with fixed one-cycle latency.

Parameters:
- ADDR_W, 12: RAM word-address width (4096 words).
- DATA_W, 16: RAM data width.
- CODE_TOP, 2048: first word address outside the code region. Words 0..CODE_TOP-1 are write-protectable.
- STARVE_LIMIT, 8: consecutive cycles a loader request may lose before it is forced through.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU fetch request, level
- cpu_addr  in  16  CPU byte address (PC); word address = cpu_addr[12:1]
- cpu_gnt  out  1  CPU request accepted this cycle (combinational)
- cpu_stall  out  1  cpu_req high and not granted this cycle
- cpu_rdata  out  16  fetched instruction, valid when cpu_valid
- cpu_valid  out  1  one-cycle pulse, the cycle after cpu_gnt
- ld_req  in  1  loader request, level
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  12  loader word address
- ld_wdata  in  16  loader write data
- code_wp  in  1  1 = writes below CODE_TOP are rejected
- ld_gnt  out  1  loader request consumed this cycle (combinational)
- ld_rdata  out  16  loader read data, valid when ld_valid
- ld_valid  out  1  one-cycle pulse, the cycle after a granted loader read
- ld_err  out  1  one-cycle pulse, the cycle after a rejected write
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  12  RAM word address
- mem_wdata  out  16  RAM write data
- mem_rdata  in  16  RAM read data, registered in RAM, valid the cycle after mem_en with mem_we=0

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high on clk.
- Reset values: ld_err, cpu_valid, ld_valid, starve counter and the owner register are all 0. cpu_rdata and ld_rdata are 0x0000.
- While reset is high, cpu_gnt, ld_gnt, mem_en and mem_we are forced to 0.
- Reset mid-operation: a read issued in the cycle before reset is not reported. No valid pulse occurs in the cycle after reset deasserts.
- Arbitration is decided combinationally each cycle. The owner register holds which port issued the previous RAM access.
- Arbitration rules:
  - cpu_req only: CPU granted.
  - ld_req only: loader granted.
  - Both requests and starve_cnt < STARVE_LIMIT: CPU granted. starve_cnt increments, saturating at STARVE_LIMIT.
  - Both requests and starve_cnt == STARVE_LIMIT: loader granted and cpu_stall=1.
- Any loader grant clears starve_cnt. starve_cnt also clears whenever ld_req is low.
- CPU access: mem_en=1, mem_we=0, mem_addr=cpu_addr[12:1]. cpu_addr[0] and cpu_addr[15:13] are ignored.
  - Next cycle: cpu_valid=1, cpu_rdata=mem_rdata.
  - cpu_rdata holds its value until the next CPU read.
- Loader read: mem_en=1, mem_we=0, mem_addr=ld_addr. Next cycle: ld_valid=1, ld_rdata=mem_rdata, held until the next loader read.
- Loader write when code_wp=0, or when ld_addr >= CODE_TOP: mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_wdata. No valid pulse follows.
- Loader write when code_wp=1 and ld_addr < CODE_TOP:
  - ld_gnt=1, so the request is consumed and the loader does not retry.
  - mem_en=0; the RAM is untouched and the slot is idle.
  - ld_err=1 on the next cycle.
  - The CPU is not granted in this slot even if it is requesting.
- Boundaries: ld_addr 2047 with code_wp=1 is rejected. ld_addr 2048 is accepted. Addresses wrap naturally within 12 bits.
- Back-to-back: a grant every cycle is legal. Valid pulses are pipelined one per cycle without bubbles.
- Owner tagging: each valid pulse is routed using the registered owner and op, never the current-cycle grant.

Test Plan:
- CPU only: reset, then cpu_req=1, cpu_addr=0x0004 with RAM word 2 = 0xA5C3 -> mem_addr=2 that cycle; next cycle cpu_valid=1, cpu_rdata=0xA5C3.
- Loader write then read: code_wp=0, write 0x1234 to 0x800, then read 0x800 -> write issues mem_we=1; read gives ld_valid=1, ld_rdata=0x1234 one cycle after its grant.
- Protection boundary: code_wp=1, write 0xBEEF to 0x7FF, then to 0x800 -> first has ld_gnt=1, mem_en=0, ld_err pulse next cycle, word 0x7FF unchanged; second writes, no ld_err.
- Starvation: cpu_req and ld_req held high continuously -> CPU granted 8 consecutive cycles, loader granted on cycle 9 with cpu_stall=1; pattern repeats every 9 cycles.
- Pipelining: CPU reads 0x0000, 0x0002, 0x0004 in consecutive cycles -> cpu_valid high for 3 consecutive cycles, data in order.
- Reset mid-read: CPU granted in cycle N, reset high in cycle N+1 -> cpu_valid stays 0 in N+1 and N+2, and starve_cnt is 0 afterwards.

Source files
------------

// File: rtl/im_arbiter.sv
// Shares the single-port instruction/dictionary RAM between the CPU fetch port and the host loader.
// The CPU has fixed priority, the loader has a starvation guard, and protected code-region writes are rejected.
module im_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int CODE_TOP     = 2048,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [15:0]       cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_valid,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              code_wp,
  output logic              ld_gnt,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_valid,
  output logic              ld_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT      = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W:0]   CODE_TOP_W = (ADDR_W + 1)'(CODE_TOP);

  typedef enum logic {OWN_CPU = 1'b0, OWN_LD = 1'b1} owner_t;

  logic [CNT_W-1:0]  r_starve_cnt;
  owner_t            r_owner;
  logic              r_rd_pend;
  logic              r_ld_err;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ld_rdata;

  logic w_starved;
  logic w_ld_win;
  logic w_cpu_win;
  logic w_protected;
  logic w_ld_reject;
  logic w_unused;

  // PC byte offset and bits above the RAM window carry no RAM address information.
  assign w_unused = ^{cpu_addr[15:ADDR_W+1], cpu_addr[0]};

  // Arbitration decision for the current slot.
  always_comb begin
    w_starved   = (r_starve_cnt == LIMIT);
    w_ld_win    = ld_req & (~cpu_req | w_starved);
    w_cpu_win   = cpu_req & ~w_ld_win;
    w_protected = code_wp & ({1'b0, ld_addr} < CODE_TOP_W);
    w_ld_reject = w_ld_win & ld_we & w_protected;
  end

  // Grants and RAM command; a rejected write consumes the slot but leaves the RAM idle.
  always_comb begin
    cpu_gnt   = ~reset & w_cpu_win;
    ld_gnt    = ~reset & w_ld_win;
    cpu_stall = cpu_req & ~cpu_gnt;
    mem_en    = ~reset & (w_cpu_win | (w_ld_win & ~w_ld_reject));
    mem_we    = ~reset & w_ld_win & ld_we & ~w_ld_reject;
    mem_wdata = ld_wdata;
    if (w_ld_win) begin
      mem_addr = ld_addr;
    end else begin
      mem_addr = cpu_addr[ADDR_W:1];
    end
  end

  // Response routing uses the owner/op captured at issue, never the current grant.
  always_comb begin
    cpu_valid = ~reset & r_rd_pend & (r_owner == OWN_CPU);
    ld_valid  = ~reset & r_rd_pend & (r_owner == OWN_LD);
    ld_err    = ~reset & r_ld_err;
    if (cpu_valid) begin
      cpu_rdata = mem_rdata;
    end else begin
      cpu_rdata = r_cpu_rdata;
    end
    if (ld_valid) begin
      ld_rdata = mem_rdata;
    end else begin
      ld_rdata = r_ld_rdata;
    end
  end

  // Starvation counter, issue tags and held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_owner      <= OWN_CPU;
      r_rd_pend    <= 1'b0;
      r_ld_err     <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ld_rdata   <= '0;
    end else begin
      if (~ld_req | w_ld_win) begin
        r_starve_cnt <= '0;
      end else if (~w_starved) begin
        r_starve_cnt <= r_starve_cnt + CNT_ONE;
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end

      if (mem_en) begin
        r_owner <= w_ld_win ? OWN_LD : OWN_CPU;
      end else begin
        r_owner <= r_owner;
      end

      r_rd_pend <= mem_en & ~mem_we;
      r_ld_err  <= w_ld_reject;

      if (cpu_valid) begin
        r_cpu_rdata <= mem_rdata;
      end else begin
        r_cpu_rdata <= r_cpu_rdata;
      end
      if (ld_valid) begin
        r_ld_rdata <= mem_rdata;
      end else begin
        r_ld_rdata <= r_ld_rdata;
      end
    end
  end

endmodule
